// File: rtl/unary_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unary_reduce_pkg
// Description : Operator encoding and elaboration helpers for the pipelined
//               unary reduction.
// Revision    : 1.0 - initial release
// ============================================================================
package unary_reduce_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    localparam int MAX_STAGES = 32;

    // Width of the vector entering stage k (k = number of stages gives 1).
    function automatic int stage_width(int n, int g, int k);
        int w;
        w = n;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (i < k) w = (w + g - 1) / g;
        end
        return w;
    endfunction

    function automatic int num_stages(int n, int g);
        int w;
        int s;
        w = n;
        s = 0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (w > 1) begin
                w = (w + g - 1) / g;
                s++;
            end
        end
        return (s < 1) ? 1 : s;
    endfunction

    // Bit offset of level k inside the flat inter-stage bus.
    function automatic int bus_offset(int n, int g, int k);
        int off;
        off = 0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (i < k) off += stage_width(n, g, i);
        end
        return off;
    endfunction

    function automatic logic identity(op_e op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

    function automatic logic is_reserved(op_e op);
        return (op == OP_RSV6) || (op == OP_RSV7);
    endfunction

    function automatic logic is_inverted(op_e op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic combine(op_e op, logic acc, logic b);
        logic r;
        case (op)
            OP_AND, OP_NAND: r = acc & b;
            OP_OR, OP_NOR:   r = acc | b;
            default:         r = acc ^ b;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unary_reduce_stage.sv
`default_nettype none
// ============================================================================
// Module      : unary_reduce_stage
// Description : One pipeline stage: reduces each G-bit group with the base
//               operator and registers the result with its valid/op.
// Revision    : 1.0 - initial release
// ============================================================================
module unary_reduce_stage
    import unary_reduce_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int G    = 4,
    localparam int OUT_W = (IN_W + G - 1) / G
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              in_valid,
    input  op_e               in_op,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    output op_e               out_op,
    output logic [OUT_W-1:0]  out_data
);

    localparam int PAD_W = OUT_W * G;

    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] reduced;
    logic             ident;

    // The partial last group is filled with the operator identity.
    always_comb begin
        ident              = identity(in_op);
        padded             = {PAD_W{ident}};
        padded[IN_W-1:0]   = in_data;
        reduced            = '0;
        for (int j = 0; j < OUT_W; j++) begin
            reduced[j] = ident;
            for (int i = 0; i < G; i++) begin
                reduced[j] = combine(in_op, reduced[j], padded[j*G + i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            out_op   <= in_op;
            out_data <= reduced;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_unary_reduce.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_unary_reduce
// Description : Valid/ready pipelined unary reduction (AND/OR/XOR and their
//               inversions) over an N-bit operand, G bits per stage.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_unary_reduce
    import unary_reduce_pkg::*;
#(
    parameter int N = 8,
    parameter int G = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         c,
    output logic         err
);

    localparam int L       = num_stages(N, G);
    localparam int BUS_W   = bus_offset(N, G, L + 1);
    localparam int RES_OFF = bus_offset(N, G, L);

    logic [BUS_W-1:0] data_bus;
    logic [L:0]       valid_bus;
    op_e              op_bus [0:L];
    logic             stall;
    logic             advance;
    op_e              last_op;

    // The whole pipeline moves or holds together.
    assign stall    = valid_bus[L] && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;

    assign data_bus[N-1:0] = a;
    assign valid_bus[0]    = in_valid;
    assign op_bus[0]       = op_e'(op);

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int IW  = stage_width(N, G, k);
        localparam int OW  = stage_width(N, G, k + 1);
        localparam int IOF = bus_offset(N, G, k);
        localparam int OOF = bus_offset(N, G, k + 1);

        unary_reduce_stage #(
            .IN_W (IW),
            .G    (G)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .in_valid  (valid_bus[k]),
            .in_op     (op_bus[k]),
            .in_data   (data_bus[IOF +: IW]),
            .out_valid (valid_bus[k+1]),
            .out_op    (op_bus[k+1]),
            .out_data  (data_bus[OOF +: OW])
        );
    end

    // Inversion and reserved-op handling act only on the final stage output.
    assign last_op   = op_bus[L];
    assign out_valid = valid_bus[L];
    assign err       = valid_bus[L] && is_reserved(last_op);
    assign c         = valid_bus[L] && !is_reserved(last_op)
                       && (data_bus[RES_OFF] ^ is_inverted(last_op));

endmodule
`default_nettype wire

// File: tb/tb_pipelined_unary_reduce.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipelined_unary_reduce
// Description : Self-checking bench for N=8, N=1 and N=13 (G=4) instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_unary_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid_v;
    logic [2:0]  out_ready_v;
    logic [12:0] a_v  [3];
    logic [2:0]  op_v [3];
    wire  [2:0]  in_ready_v;
    wire  [2:0]  out_valid_v;
    wire  [2:0]  c_v;
    wire  [2:0]  err_v;

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  expq [3][$];
    int          acc_cnt [3];
    logic        prev_stall [3];
    logic [2:0]  prev_out [3];
    int          wid [3];

    always #5 clk = ~clk;

    pipelined_unary_reduce #(.N(8), .G(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][7:0]), .op(op_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .c(c_v[0]), .err(err_v[0]));

    pipelined_unary_reduce #(.N(1), .G(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][0:0]), .op(op_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .c(c_v[1]), .err(err_v[1]));

    pipelined_unary_reduce #(.N(13), .G(4)) dut13 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .op(op_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .c(c_v[2]), .err(err_v[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: {err, c} from bit population of the operand.
    function automatic logic [1:0] model(int w, logic [12:0] x, int o);
        int   ones;
        logic r;
        ones = 0;
        for (int i = 0; i < w; i++) ones += int'(x[i]);
        if (o > 5) return 2'b10;
        case (o % 3)
            0:       r = (ones == w);
            1:       r = (ones != 0);
            default: r = ones[0];
        endcase
        if (o >= 3) r = ~r;
        return {1'b0, r};
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                expq[d].delete();
                prev_stall[d] = 1'b0;
            end else begin
                if (prev_stall[d])
                    check("stall_hold", {out_valid_v[d], c_v[d], err_v[d]}, prev_out[d]);
                if (out_valid_v[d] && out_ready_v[d]) begin
                    if (expq[d].size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        logic [1:0] e;
                        e = expq[d].pop_front();
                        check("result_c", c_v[d], e[0]);
                        check("result_err", err_v[d], e[1]);
                    end
                end
                if (in_valid_v[d] && in_ready_v[d]) begin
                    expq[d].push_back(model(wid[d], a_v[d], int'(op_v[d])));
                    acc_cnt[d]++;
                end
                prev_stall[d] = out_valid_v[d] && !out_ready_v[d];
                prev_out[d]   = {out_valid_v[d], c_v[d], err_v[d]};
            end
        end
    end

    task automatic send_check(input logic [7:0] av, input int o, input logic ec, input logic ee);
        @(posedge clk); #1;
        in_valid_v[0] = 1'b1;
        a_v[0]        = {5'b0, av};
        op_v[0]       = o[2:0];
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        check("lat1_out_valid", out_valid_v[0], 0);
        @(negedge clk);
        check("lat2_out_valid", out_valid_v[0], 1);
        check("lat2_c", c_v[0], ec);
        check("lat2_err", err_v[0], ee);
    endtask

    task automatic rand_run(input int d);
        int guard;
        bit done;
        guard = 0;
        done  = 1'b0;
        fork
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready_v[d] = ($urandom_range(0, 2) != 0);
                end
            end
            begin
                while (acc_cnt[d] < 1000 && guard < 20000) begin
                    @(posedge clk); #1;
                    if (acc_cnt[d] < 1000) begin
                        in_valid_v[d] = ($urandom_range(0, 3) != 0);
                        a_v[d]        = 13'($urandom);
                        op_v[d]       = 3'($urandom_range(0, 7));
                    end
                    guard++;
                end
                in_valid_v[d] = 1'b0;
                done = 1'b1;
            end
        join
        check("rand_accept_count", acc_cnt[d], 1000);
        out_ready_v[d] = 1'b1;
    endtask

    initial begin
        int   ops [4];
        logic exp_c [4];
        ops   = '{1, 2, 4, 5};
        exp_c = '{1'b1, 1'b1, 1'b0, 1'b0};
        wid   = '{8, 1, 13};
        rst         = 1'b1;
        in_valid_v  = '0;
        out_ready_v = 3'b111;
        for (int d = 0; d < 3; d++) begin
            a_v[d] = '0; op_v[d] = '0; acc_cnt[d] = 0;
            prev_stall[d] = 1'b0; prev_out[d] = '0;
        end

        check("model_and_ff", model(8, 13'h0FF, 0), 2'b01);
        check("model_xor_07", model(8, 13'h007, 2), 2'b01);
        check("model_xnor13", model(13, 13'h1001, 5), 2'b01);
        check("model_rsv", model(8, 13'h0FF, 7), 2'b10);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_out_valid", out_valid_v[d], 0);
            check("reset_c", c_v[d], 0);
            check("reset_err", err_v[d], 0);
            check("reset_in_ready", in_ready_v[d], 1);
        end

        send_check(8'hFF, 0, 1'b1, 1'b0);
        send_check(8'hFE, 0, 1'b0, 1'b0);

        // Four back-to-back ops on a=01: OR, XOR, NOR, XNOR.
        @(posedge clk); #1;
        in_valid_v[0] = 1'b1; a_v[0] = 13'h001; op_v[0] = 3'(ops[0]);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) op_v[0] = 3'(ops[i+1]);
            else       in_valid_v[0] = 1'b0;
            @(negedge clk);
            if (i >= 1) begin
                check("b2b_valid", out_valid_v[0], 1);
                check("b2b_c", c_v[0], exp_c[i-1]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("b2b_valid", out_valid_v[0], 1);
        check("b2b_c", c_v[0], exp_c[3]);

        // Backpressure with three offered inputs.
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        in_valid_v[0] = 1'b1; a_v[0] = 13'h0FF; op_v[0] = 3'd0;
        @(posedge clk); #1;
        a_v[0] = 13'h000; op_v[0] = 3'd1;
        @(posedge clk); #1;
        a_v[0] = 13'h007; op_v[0] = 3'd2;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready_v[0], 0);
            check("bp_out_valid", out_valid_v[0], 1);
            check("bp_c", c_v[0], 1);
        end
        @(posedge clk); #1 out_ready_v[0] = 1'b1;
        @(posedge clk); #1 in_valid_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_drained", expq[0].size(), 0);

        send_check(8'hFF, 6, 1'b0, 1'b1);
        send_check(8'h01, 1, 1'b1, 1'b0);

        // Reset with two results in flight.
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        in_valid_v[0] = 1'b1; a_v[0] = 13'h0FF; op_v[0] = 3'd1;
        @(posedge clk); #1;
        a_v[0] = 13'h000; op_v[0] = 3'd0;
        @(posedge clk); #1 in_valid_v[0] = 1'b0;
        @(negedge clk);
        check("inflight_valid", out_valid_v[0], 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; out_ready_v[0] = 1'b1;
        @(negedge clk);
        check("post_rst_valid", out_valid_v[0], 0);
        check("post_rst_in_ready", in_ready_v[0], 1);
        repeat (4) begin
            @(negedge clk);
            check("no_stale", out_valid_v[0], 0);
        end

        fork
            rand_run(1);
            rand_run(2);
        join
        repeat (10) @(posedge clk);
        for (int d = 0; d < 3; d++) check("final_drained", expq[d].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_unary_reduce.md
PIPELINED_UNARY_REDUCE -- requirements
Module: pipelined_unary_reduce

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width in bits (N >= 1).
REQ-002 The block SHALL have parameter G, default 4, giving the group size each pipeline stage reduces (G >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand and op are presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an input this cycle.
REQ-007 The block SHALL have port a, input, N bits: the operand.
REQ-008 The block SHALL have port op, input, 3 bits: the reduction operator, encoded per REQ-013.
REQ-009 The block SHALL have port out_valid, output, 1 bit: c and err are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port c, output, 1 bit: the reduction result.
REQ-012 The block SHALL have port err, output, 1 bit: the op code was reserved.

Function
REQ-013 op encoding SHALL be 0=AND, 1=OR, 2=XOR, 3=NAND, 4=NOR, 5=XNOR; codes 6 and 7 are reserved.
REQ-014 Transfer SHALL occur on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-015 Latency L SHALL equal the number of stages, ceil(log_G(N)), with a minimum of 1 (N=8,G=4 gives L=2; N=1 gives L=1; N=64,G=4 gives L=3).
REQ-016 Each stage SHALL reduce groups of G bits with the base operator (AND, OR or XOR); a partial final group is padded with the identity (1 for AND, 0 for OR/XOR).
REQ-017 Inversion for NAND, NOR and XNOR SHALL be applied only at the final stage output.
REQ-018 op SHALL be carried in a valid-qualified register alongside the data through every stage.
REQ-019 The pipeline SHALL advance as a whole: stall = out_valid && !out_ready; in_ready = !stall.
REQ-020 While stalled, all stage registers, c, err and out_valid SHALL hold their values unchanged.
REQ-021 Bubbles (stages holding valid=0) SHALL advance while not stalled, so the block sustains one result per cycle when out_ready=1.
REQ-022 A reserved op SHALL produce c=0 and err=1 with the same latency; for valid ops err=0.
REQ-023 Results SHALL emerge in acceptance order, with no loss or duplication under any valid/ready pattern.
REQ-024 in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-025 While rst=1 at a clock edge, all stage valid bits, out_valid, c and err SHALL clear to 0; data registers need no reset.
REQ-026 Reset mid-operation SHALL discard all in-flight results; in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-027 Package unary_reduce_pkg SHALL hold the op_e enum (6 ops plus reserved), a function computing the stage count from N and G, and a function computing the identity value per op.
REQ-028 A sub-module unary_reduce_stage (parameters: input width, G) SHALL implement one group-reduce plus its valid/op register, instantiated L times by generate.

Verification
REQ-029 N=8, G=4: a=8'hFF, op=AND, out_ready=1 -> c=1, err=0 exactly 2 cycles after acceptance; a=8'hFE, op=AND -> c=0.
REQ-030 N=8: back-to-back a=8'h01 with op=OR, XOR, NOR, XNOR -> c=1,1,0,0 on four consecutive cycles.
REQ-031 Hold out_ready=0 while 3 inputs are offered -> in_ready drops once out_valid=1 and the outputs hold stable; release -> all accepted results appear in order.
REQ-032 op=6 with a=8'hFF -> c=0, err=1 at latency 2; the next op=OR result has err=0.
REQ-033 Assert rst with 2 results in flight -> out_valid=0 the next cycle, no stale result emerges, and in_ready=1 after release.
REQ-034 N=1 (L=1) and N=13, G=4 (L=2, padding): randomized a/op checked against a reference model, with 1000 transactions under random backpressure.
